// File: rtl/dpu_seq_pkg.sv
// DPU opcodes, register-file indices and draw-sequencer state encoding, shared with the DPU.
package dpu_seq_pkg;

  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_SHL = 2;
  localparam int OP_CMP = 6;
  localparam int OP_LD  = 8;
  localparam int OP_NOP = 15;

  localparam int REG_DX     = 0;
  localparam int REG_DY     = 1;
  localparam int REG_ERR    = 2;
  localparam int REG_EINC   = 3;
  localparam int REG_ENOINC = 4;
  localparam int REG_XS     = 5;
  localparam int REG_XE     = 6;
  localparam int REG_YS     = 7;
  localparam int REG_YE     = 8;
  localparam int REG_X      = 9;
  localparam int REG_Y      = 10;
  localparam int REG_COL    = 11;
  localparam int REG_ONE    = 12;
  localparam int REG_ZERO   = 13;

  typedef enum logic [3:0] {
    S_IDLE, S_PT, S_LOAD, S_SETUP, S_PLOT, S_TEST,
    S_ADDE, S_INCY, S_UPDE, S_INCX, S_DONE
  } seq_state_t;

endpackage

// File: rtl/dpu_draw_seq.sv
// POINT/LINE micro-op sequencer for the DPU register file; octant-0 Bresenham on the DPU sign flag.
// Latency: POINT plots 4 cycles after handshake, LINE first plot after 15, then 4 or 5 cycles per pixel.
// Backpressure: cmd_ready only in IDLE; DPU_SEQ_ABORT_EN adds an abort input that ends a command early.
module dpu_draw_seq
  import dpu_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int RA_W   = 4,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_line,
  input  logic [DATA_W-1:0] cmd_x0,
  input  logic [DATA_W-1:0] cmd_y0,
  input  logic [DATA_W-1:0] cmd_x1,
  input  logic [DATA_W-1:0] cmd_y1,
  input  logic [DATA_W-1:0] cmd_col,
  output logic [RA_W-1:0]   dpu_a,
  output logic [RA_W-1:0]   dpu_b,
  output logic [RA_W-1:0]   dpu_r,
  output logic [OP_W-1:0]   dpu_n,
  output logic [DATA_W-1:0] dpu_mdata,
  input  logic [3:0]        dpu_cc,
`ifdef DPU_SEQ_ABORT_EN
  input  logic              abort,
`endif
  output logic              plot_stb,
  output logic              busy,
  output logic              done,
  output logic              cmd_err
);

  typedef struct packed {
    logic [OP_W-1:0]   n;
    logic [RA_W-1:0]   a;
    logic [RA_W-1:0]   b;
    logic [RA_W-1:0]   r;
    logic [DATA_W-1:0] m;
  } uop_t;

  function automatic uop_t mk(input int n, input int a, input int b, input int r,
                              input logic [DATA_W-1:0] m);
    uop_t u;
    u.n = OP_W'(n);
    u.a = RA_W'(a);
    u.b = RA_W'(b);
    u.r = RA_W'(r);
    u.m = m;
    return u;
  endfunction

  seq_state_t        state;
  uop_t              uop;
  uop_t              load_op;
  uop_t              setup_op;
  uop_t              cmp_op;
  logic [3:0]        step;
  logic [3:0]        step_nx;
  logic [3:0]        setup_idx;
  logic [DATA_W-1:0] x0_q, y0_q, x1_q, y1_q, col_q;
  logic [DATA_W-1:0] cnt;
  logic [DATA_W-1:0] dx_in;
  logic [DATA_W-1:0] dy_in;
  logic              line_ok;
  logic              abort_now;
  logic              unused_cc;

  assign unused_cc = ^dpu_cc[2:0];

  assign dx_in     = cmd_x1 - cmd_x0;
  assign dy_in     = cmd_y1 - cmd_y0;
  assign line_ok   = (cmd_x1 >= cmd_x0) && (cmd_y1 >= cmd_y0) && (dy_in <= dx_in);
  assign step_nx   = step + 4'd1;
  assign setup_idx = (state == S_SETUP) ? step_nx : 4'd0;
  assign cmp_op    = mk(OP_CMP, REG_ERR, REG_ZERO, 0, '0);

`ifdef DPU_SEQ_ABORT_EN
  // A command already in DONE has finished; aborting it would double-pulse done.
  assign abort_now = abort && (state != S_IDLE) && (state != S_DONE);
`else
  assign abort_now = 1'b0;
`endif

  always_comb begin
    load_op = mk(OP_LD, 0, 0, REG_XS, x0_q);
    case (step_nx)
      4'd1: load_op = mk(OP_LD, 0, 0, REG_YS, y0_q);
      4'd2: load_op = mk(OP_LD, 0, 0, REG_XE, x1_q);
      4'd3: load_op = mk(OP_LD, 0, 0, REG_YE, y1_q);
      4'd4: load_op = mk(OP_LD, 0, 0, REG_COL, col_q);
      4'd5: load_op = mk(OP_LD, 0, 0, REG_ONE, DATA_W'(1));
      4'd6: load_op = mk(OP_LD, 0, 0, REG_ZERO, '0);
      4'd7: load_op = mk(OP_LD, 0, 0, REG_X, x0_q);
      4'd8: load_op = mk(OP_LD, 0, 0, REG_Y, y0_q);
      default: ;
    endcase
  end

  always_comb begin
    setup_op = mk(OP_SUB, REG_YE, REG_YS, REG_DY, '0);
    case (setup_idx)
      4'd1: setup_op = mk(OP_SUB, REG_XE, REG_XS, REG_DX, '0);
      4'd2: setup_op = mk(OP_SHL, REG_DY, 0, REG_ENOINC, '0);
      4'd3: setup_op = mk(OP_SUB, REG_ENOINC, REG_DX, REG_ERR, '0);
      4'd4: setup_op = mk(OP_SUB, REG_ERR, REG_DX, REG_EINC, '0);
      default: ;
    endcase
  end

  // Outputs for a state are registered on the edge that enters it, so each
  // transition below also loads the micro-op that the next state presents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      uop      <= mk(OP_NOP, 0, 0, 0, '0);
      plot_stb <= 1'b0;
      done     <= 1'b0;
      cmd_err  <= 1'b0;
      step     <= '0;
      cnt      <= '0;
      x0_q     <= '0;
      y0_q     <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      col_q    <= '0;
    end else begin
      uop      <= mk(OP_NOP, 0, 0, 0, '0);
      plot_stb <= 1'b0;
      done     <= 1'b0;
      cmd_err  <= 1'b0;
      if (abort_now) begin
        state   <= S_DONE;
        done    <= 1'b1;
        cmd_err <= 1'b1;
      end else begin
        case (state)
          S_IDLE: if (cmd_valid) begin
            x0_q  <= cmd_x0;
            y0_q  <= cmd_y0;
            x1_q  <= cmd_x1;
            y1_q  <= cmd_y1;
            col_q <= cmd_col;
            step  <= '0;
            if (!cmd_line) begin
              state <= S_PT;
              cnt   <= '0;
              uop   <= mk(OP_LD, 0, 0, REG_X, cmd_x0);
            end else if (line_ok) begin
              state <= S_LOAD;
              cnt   <= dx_in;
              uop   <= mk(OP_LD, 0, 0, REG_XS, cmd_x0);
            end else begin
              state   <= S_DONE;
              done    <= 1'b1;
              cmd_err <= 1'b1;
            end
          end
          S_PT: begin
            step <= step_nx;
            if (step == 4'd0) begin
              uop <= mk(OP_LD, 0, 0, REG_Y, y0_q);
            end else if (step == 4'd1) begin
              uop <= mk(OP_LD, 0, 0, REG_COL, col_q);
            end else begin
              state    <= S_PLOT;
              plot_stb <= 1'b1;
            end
          end
          S_LOAD: begin
            uop <= (step == 4'd8) ? setup_op : load_op;
            if (step == 4'd8) begin
              state <= S_SETUP;
              step  <= '0;
            end else begin
              step <= step_nx;
            end
          end
          S_SETUP: begin
            if (step == 4'd4) begin
              state    <= S_PLOT;
              plot_stb <= 1'b1;
              if (cnt != '0) uop <= cmp_op;
            end else begin
              step <= step_nx;
              uop  <= setup_op;
            end
          end
          S_PLOT: begin
            if (cnt == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_TEST;
            end
          end
          S_TEST: begin
            if (dpu_cc[3]) begin
              state <= S_ADDE;
              uop   <= mk(OP_ADD, REG_ERR, REG_ENOINC, REG_ERR, '0);
            end else begin
              state <= S_INCY;
              uop   <= mk(OP_ADD, REG_Y, REG_ONE, REG_Y, '0);
            end
          end
          S_INCY: begin
            state <= S_UPDE;
            uop   <= mk(OP_ADD, REG_ERR, REG_EINC, REG_ERR, '0);
          end
          S_ADDE, S_UPDE: begin
            state <= S_INCX;
            cnt   <= cnt - DATA_W'(1);
            uop   <= mk(OP_ADD, REG_X, REG_ONE, REG_X, '0);
          end
          S_INCX: begin
            state    <= S_PLOT;
            plot_stb <= 1'b1;
            if (cnt != '0) uop <= cmp_op;
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign dpu_n     = uop.n;
  assign dpu_a     = uop.a;
  assign dpu_b     = uop.b;
  assign dpu_r     = uop.r;
  assign dpu_mdata = uop.m;
  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_dpu_draw_seq.sv
// Bench for dpu_draw_seq: a behavioural DPU register file executes the micro-ops and a pixel
// scoreboard compares the X/Y/Col registers at every plot_stb.
module tb_dpu_draw_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_line = 1'b0;
  logic [7:0] cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0, cmd_col = '0;
  logic       cmd_ready;
  logic [3:0] dpu_a, dpu_b, dpu_r, dpu_n;
  logic [7:0] dpu_mdata;
  logic [3:0] dpu_cc;
  logic       plot_stb, busy, done, cmd_err;
`ifdef DPU_SEQ_ABORT_EN
  logic       abort = 1'b0;
`endif

  always #5 clk = ~clk;

  dpu_draw_seq #(.DATA_W(8), .RA_W(4), .OP_W(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_line(cmd_line),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1), .cmd_col(cmd_col),
    .dpu_a(dpu_a), .dpu_b(dpu_b), .dpu_r(dpu_r), .dpu_n(dpu_n), .dpu_mdata(dpu_mdata),
    .dpu_cc(dpu_cc),
`ifdef DPU_SEQ_ABORT_EN
    .abort(abort),
`endif
    .plot_stb(plot_stb), .busy(busy), .done(done), .cmd_err(cmd_err)
  );

  // DPU: 16-bit registers so Err never overflows on long spans; flags registered on CMP.
  logic [15:0] rf [16];
  logic [15:0] cmp_d;
  logic [23:0] kbus;
  assign cmp_d = rf[dpu_a] - rf[dpu_b];
  assign kbus  = {rf[9][7:0], rf[10][7:0], rf[11][7:0]};

  always @(posedge clk) begin
    case (dpu_n)
      4'd0: rf[dpu_r] <= rf[dpu_a] + rf[dpu_b];
      4'd1: rf[dpu_r] <= rf[dpu_a] - rf[dpu_b];
      4'd2: rf[dpu_r] <= rf[dpu_a] << 1;
      4'd6: dpu_cc <= {cmp_d[15], 3'b000};
      4'd8: rf[dpu_r] <= {8'h00, dpu_mdata};
      default: ;
    endcase
  end

  int cmp_n = 0, err_n = 0, cyc = 0;
  int plots_seen = 0, ops_seen = 0, cmps_seen = 0, dones_seen = 0;
  int first_plot_cyc = 0, last_plot_cyc = 0;
  logic [31:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_n++;
    assert (obs === exp) else begin
      err_n++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (dpu_n != 4'hf) ops_seen++;
      if (dpu_n == 4'd6) cmps_seen++;
      if (done) dones_seen++;
      if (plot_stb) begin
        logic [31:0] e;
        plots_seen++;
        if (plots_seen == 1) first_plot_cyc = cyc;
        last_plot_cyc = cyc;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h8000_0000;
        check("pixel", {8'h00, kbus}, e);
      end
    end
  end

  task automatic push_line(input int x0, input int y0, input int x1, input int y1, input int col);
    int dx = x1 - x0;
    int dy = y1 - y0;
    int e = 2 * dy - dx;
    int y = y0;
    for (int x = x0; x <= x1; x++) begin
      exp_q.push_back({8'h00, 8'(x), 8'(y), 8'(col)});
      if (e < 0) e += 2 * dy;
      else begin
        y++;
        e += 2 * dy - 2 * dx;
      end
    end
  endtask

  task automatic send(input logic line, input int x0, input int y0, input int x1, input int y1,
                      input int col, output int hs);
    for (int t = 0; t < 100 && !cmd_ready; t++) @(negedge clk);
    check("ready_wait", {31'h0, cmd_ready}, 1);
    plots_seen = 0;
    ops_seen   = 0;
    cmps_seen  = 0;
    cmd_line = line;
    cmd_x0 = 8'(x0); cmd_y0 = 8'(y0); cmd_x1 = 8'(x1); cmd_y1 = 8'(y1); cmd_col = 8'(col);
    cmd_valid = 1'b1;
    hs = cyc;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_x0 = 8'($urandom); cmd_y0 = 8'($urandom); cmd_x1 = 8'($urandom);
    cmd_y1 = 8'($urandom); cmd_col = 8'($urandom);
  endtask

  task automatic wait_done(input int budget, output int dc, output logic de);
    dc = -1;
    de = 1'bx;
    for (int t = 0; t < budget; t++) begin
      @(negedge clk);
      if (done) begin
        dc = cyc;
        de = cmd_err;
        break;
      end
    end
    check("done_seen", 32'(dc >= 0), 1);
  endtask

  initial begin
    int hs, d, dn;
    logic e;

    repeat (3) @(negedge clk);
    check("rst_dpu", {8'h00, dpu_n, dpu_a, dpu_b, dpu_r, dpu_mdata}, 32'h00f0_0000);
    check("rst_flags", {27'h0, plot_stb, busy, done, cmd_err, cmd_ready}, 32'h1);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'h0, cmd_ready}, 1);

    // POINT: plot 4 cycles after handshake, done the cycle after.
    push_line(10, 20, 10, 20, 3);
    send(1'b0, 10, 20, 0, 0, 3, hs);
    wait_done(50, d, e);
    check("pt_plots", plots_seen, 1);
    check("pt_plot_lat", first_plot_cyc - hs, 4);
    check("pt_done_lat", d - last_plot_cyc, 1);
    check("pt_err", {31'h0, e}, 0);

    // LINE with mixed 4/5-cycle pixels; command traffic while busy must be ignored.
    push_line(0, 0, 4, 2, 7);
    send(1'b1, 0, 0, 4, 2, 7, hs);
    cmd_line = 1'b0; cmd_x0 = 8'd99; cmd_y0 = 8'd99; cmd_valid = 1'b1;
    repeat (5) @(negedge clk);
    check("busy_ignores_valid", {30'h0, busy, cmd_ready}, 32'h2);
    cmd_valid = 1'b0;
    wait_done(200, d, e);
    check("line_plots", plots_seen, 5);
    check("line_first_lat", first_plot_cyc - hs, 15);
    check("line_done_lat", d - last_plot_cyc, 1);
    check("line_err", {31'h0, e}, 0);

    // Back-to-back degenerate line: accepted the cycle after done, one plot, no CMP.
    dn = d;
    push_line(5, 5, 5, 5, 9);
    send(1'b1, 5, 5, 5, 5, 9, hs);
    check("b2b_accept", hs - dn, 1);
    wait_done(50, d, e);
    check("deg_plots", plots_seen, 1);
    check("deg_cmps", cmps_seen, 0);

    // Rejected lines: x1<x0, then slope > 1.
    send(1'b1, 5, 0, 2, 0, 1, hs);
    wait_done(10, d, e);
    check("inv1_err", {31'h0, e}, 1);
    check("inv1_lat", d - hs, 1);
    check("inv1_plots_ops", {plots_seen[15:0], ops_seen[15:0]}, 0);
    send(1'b1, 0, 0, 1, 3, 1, hs);
    wait_done(10, d, e);
    check("inv2_err", {31'h0, e}, 1);
    check("inv2_plots_ops", {plots_seen[15:0], ops_seen[15:0]}, 0);

    // Widest span: 256 plots, counter must not wrap.
    push_line(0, 0, 255, 3, 1);
    send(1'b1, 0, 0, 255, 3, 1, hs);
    wait_done(3000, d, e);
    check("span_plots", plots_seen, 256);
    check("span_q_empty", exp_q.size(), 0);

    // Reset during the 3rd pixel of a diagonal line.
    push_line(0, 0, 9, 9, 2);
    send(1'b1, 0, 0, 9, 9, 2, hs);
    for (int t = 0; t < 200 && plots_seen < 3; t++) @(negedge clk);
    check("third_pixel_reached", plots_seen, 3);
    rst = 1'b1;
    #1;
    check("mid_rst_dpu", {8'h00, dpu_n, dpu_a, dpu_b, dpu_r, dpu_mdata}, 32'h00f0_0000);
    check("mid_rst_flags", {27'h0, plot_stb, busy, done, cmd_err, cmd_ready}, 32'h1);
    exp_q.delete();
    dn = dones_seen;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("no_done_after_rst", dones_seen, dn);
    push_line(1, 1, 1, 1, 4);
    send(1'b0, 1, 1, 0, 0, 4, hs);
    wait_done(50, d, e);
    check("post_rst_pt_plots", plots_seen, 1);
    check("post_rst_pt_err", {31'h0, e}, 0);

`ifdef DPU_SEQ_ABORT_EN
    // Abort during SETUP (cycles hs+10..hs+14).
    send(1'b1, 0, 0, 200, 100, 5, hs);
    while (cyc < hs + 11) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_done_err_nop", {26'h0, done, cmd_err, dpu_n}, 32'h3f);
    @(negedge clk);
    check("abort_idle", {31'h0, busy}, 0);
    check("abort_plots", plots_seen, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
